// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS EX stage: ALU opcodes, control bit positions
// and the multiply/divide sequencer states.
package mips_pkg;

    localparam logic [3:0] AluAnd   = 4'd0;
    localparam logic [3:0] AluOr    = 4'd1;
    localparam logic [3:0] AluAdd   = 4'd2;
    localparam logic [3:0] AluXor   = 4'd3;
    localparam logic [3:0] AluNor   = 4'd4;
    localparam logic [3:0] AluSll   = 4'd5;
    localparam logic [3:0] AluSub   = 4'd6;
    localparam logic [3:0] AluSlt   = 4'd7;
    localparam logic [3:0] AluSltu  = 4'd8;
    localparam logic [3:0] AluMult  = 4'd9;
    localparam logic [3:0] AluMultu = 4'd10;
    localparam logic [3:0] AluDiv   = 4'd11;
    localparam logic [3:0] AluDivu  = 4'd12;
    localparam logic [3:0] AluMfhi  = 4'd13;
    localparam logic [3:0] AluMflo  = 4'd14;
    localparam logic [3:0] AluSrl   = 4'd15;

    localparam int unsigned MuxRegWrite = 0;
    localparam int unsigned MuxMemToReg = 1;
    localparam int unsigned MuxRegDst   = 2;
    localparam int unsigned MuxBIsImm   = 3;

    localparam int unsigned MemRead  = 0;
    localparam int unsigned MemWrite = 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} muldiv_state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == AluMult) || (op == AluMultu) || (op == AluDiv) || (op == AluDivu);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide into HI/LO: one shift-add or restoring-subtract step
// per cycle on operand magnitudes, sign correction applied on the last step.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_start,
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam int unsigned CntW = $clog2(MULDIV_CYCLES);
    localparam logic [CntW-1:0] LastCnt = CntW'(MULDIV_CYCLES - 1);

    muldiv_state_e   r_state, w_state_next;
    logic [CntW-1:0] r_cnt;
    logic [63:0]     r_acc;
    logic [31:0]     r_opnd, r_dividend, r_hi, r_lo;
    logic            r_is_div, r_neg_q, r_neg_r, r_div0;

    logic            w_signed, w_is_div, w_a_neg, w_b_neg, w_ge;
    logic [31:0]     w_a_mag, w_b_mag, w_diff, w_quo, w_rem, w_fin_hi, w_fin_lo;
    logic [32:0]     w_sum, w_shift;
    logic [63:0]     w_step, w_prod;

    assign w_signed = (i_op == AluMult) || (i_op == AluDiv);
    assign w_is_div = (i_op == AluDiv) || (i_op == AluDivu);
    assign w_a_neg  = w_signed & i_a[31];
    assign w_b_neg  = w_signed & i_b[31];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_next = StBusy;
            StBusy:  if (r_cnt == LastCnt) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Stall must drop the instant reset asserts, even with a mul/div still at the input.
    always_comb begin
        o_stall = ~reset & (((r_state == StIdle) & i_start) | (r_state == StBusy));
        o_done  = (r_state == StDone);
    end

    // Mult keeps {partial, multiplier}; div keeps {remainder, quotient} in r_acc.
    always_comb begin
        w_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
        w_shift = r_acc[63:31];
        w_ge    = w_shift >= {1'b0, r_opnd};
        w_diff  = w_shift[31:0] - r_opnd;
        if (r_is_div) w_step = {(w_ge ? w_diff : w_shift[31:0]), r_acc[30:0], w_ge};
        else          w_step = {w_sum, r_acc[31:1]};
        w_prod = r_neg_q ? -w_step : w_step;
        w_quo  = r_neg_q ? -w_step[31:0] : w_step[31:0];
        w_rem  = r_neg_r ? -w_step[63:32] : w_step[63:32];
        if (!r_is_div) begin
            {w_fin_hi, w_fin_lo} = w_prod;
        end else if (r_div0) begin
            w_fin_hi = r_dividend;
            w_fin_lo = 32'hFFFF_FFFF;
        end else begin
            w_fin_hi = w_rem;
            w_fin_lo = w_quo;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_acc      <= 64'd0;
            r_opnd     <= 32'd0;
            r_dividend <= 32'd0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
        end else if (r_state == StIdle && i_start) begin
            r_cnt      <= '0;
            r_is_div   <= w_is_div;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_div0     <= (i_b == 32'd0);
            r_dividend <= i_a;
            r_acc      <= {32'd0, (w_is_div ? w_a_mag : w_b_mag)};
            r_opnd     <= w_is_div ? w_b_mag : w_a_mag;
        end else if (r_state == StBusy) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LastCnt) begin
                r_hi <= w_fin_hi;
                r_lo <= w_fin_lo;
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: operand forwarding, ALU, multi-cycle mul/div into HI/LO, and
// the EX/MEM pipeline register.
module execute_stage
    import mips_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] d1_in,
    input  logic [31:0] d2_in,
    input  logic [4:0]  rs_in,
    input  logic [4:0]  rt_in,
    input  logic [4:0]  rd_in,
    input  logic [6:0]  muxctrl_in,
    input  logic [1:0]  memctrl_in,
    input  logic [3:0]  aluctrl_in,
    input  logic [31:0] fwd_exmem_data,
    input  logic [4:0]  fwd_exmem_dest,
    input  logic        fwd_exmem_we,
    input  logic [31:0] fwd_memwb_data,
    input  logic [4:0]  fwd_memwb_dest,
    input  logic        fwd_memwb_we,
    output logic        stall,
    output logic [31:0] alu_result,
    output logic [31:0] store_data,
    output logic [4:0]  dest_out,
    output logic [6:0]  muxctrl_out,
    output logic [1:0]  memctrl_out
);

    logic [31:0] w_op_a, w_rt_fwd, w_op_b, w_alu, w_hi, w_lo;
    logic [4:0]  w_dest;
    logic [6:0]  w_mux;
    logic        w_done;

    always_comb begin
        if (fwd_exmem_we && fwd_exmem_dest == rs_in && rs_in != 5'd0)      w_op_a = fwd_exmem_data;
        else if (fwd_memwb_we && fwd_memwb_dest == rs_in && rs_in != 5'd0) w_op_a = fwd_memwb_data;
        else                                                               w_op_a = d1_in;
    end

    always_comb begin
        if (fwd_exmem_we && fwd_exmem_dest == rt_in && rt_in != 5'd0)      w_rt_fwd = fwd_exmem_data;
        else if (fwd_memwb_we && fwd_memwb_dest == rt_in && rt_in != 5'd0) w_rt_fwd = fwd_memwb_data;
        else                                                               w_rt_fwd = d2_in;
    end

    assign w_op_b = muxctrl_in[MuxBIsImm] ? d2_in : w_rt_fwd;
    assign w_dest = muxctrl_in[MuxRegDst] ? rd_in : rt_in;

    always_comb begin
        w_alu = 32'd0;
        case (aluctrl_in)
            AluAnd:  w_alu = w_op_a & w_op_b;
            AluOr:   w_alu = w_op_a | w_op_b;
            AluAdd:  w_alu = w_op_a + w_op_b;
            AluXor:  w_alu = w_op_a ^ w_op_b;
            AluNor:  w_alu = ~(w_op_a | w_op_b);
            AluSll:  w_alu = w_op_a << w_op_b[4:0];
            AluSub:  w_alu = w_op_a - w_op_b;
            AluSlt:  w_alu = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
            AluSltu: w_alu = {31'd0, w_op_a < w_op_b};
            AluMfhi: w_alu = w_hi;
            AluMflo: w_alu = w_lo;
            AluSrl:  w_alu = w_op_a >> w_op_b[4:0];
            default: w_alu = 32'd0;
        endcase
    end

    // A finished mul/div retires through EX/MEM without writing the register file.
    always_comb begin
        w_mux = muxctrl_in;
        if (w_done) w_mux[MuxRegWrite] = 1'b0;
    end

    muldiv_unit #(
        .MULDIV_CYCLES(MULDIV_CYCLES)
    ) u_muldiv (
        .clock   (clock),
        .reset   (reset),
        .i_start (is_muldiv(aluctrl_in)),
        .i_op    (aluctrl_in),
        .i_a     (w_op_a),
        .i_b     (w_op_b),
        .o_stall (stall),
        .o_done  (w_done),
        .o_hi    (w_hi),
        .o_lo    (w_lo)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset || stall) begin
            alu_result  <= 32'd0;
            store_data  <= 32'd0;
            dest_out    <= 5'd0;
            muxctrl_out <= 7'd0;
            memctrl_out <= 2'd0;
        end else begin
            alu_result  <= w_alu;
            store_data  <= w_rt_fwd;
            dest_out    <= w_dest;
            muxctrl_out <= w_mux;
            memctrl_out <= memctrl_in;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: a cycle-level reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_execute_stage;

    localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2, OP_XOR = 4'd3;
    localparam logic [3:0] OP_NOR = 4'd4, OP_SLL = 4'd5, OP_SUB = 4'd6, OP_SLT = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8, OP_MULT = 4'd9, OP_MULTU = 4'd10, OP_DIV = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12, OP_MFHI = 4'd13, OP_MFLO = 4'd14, OP_SRL = 4'd15;
    localparam int MdStall = 33;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] d1_in, d2_in, fwd_exmem_data, fwd_memwb_data;
    logic [4:0]  rs_in, rt_in, rd_in, fwd_exmem_dest, fwd_memwb_dest;
    logic [6:0]  muxctrl_in;
    logic [1:0]  memctrl_in;
    logic [3:0]  aluctrl_in;
    logic        fwd_exmem_we, fwd_memwb_we;
    logic        stall;
    logic [31:0] alu_result, store_data;
    logic [4:0]  dest_out;
    logic [6:0]  muxctrl_out;
    logic [1:0]  memctrl_out;

    int n_vec = 0;
    int n_bad = 0;
    bit m_ready = 1'b0;

    // Reference model state: expected EX/MEM contents and architectural HI/LO.
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] e_alu = 0, e_store = 0;
    logic [4:0]  e_dest = 0;
    logic [6:0]  e_mux = 0;
    logic [1:0]  e_mem = 0;
    bit          e_alu_v = 1'b1, e_full = 1'b1;

    always #5 clock = ~clock;

    execute_stage #(
        .MULDIV_CYCLES(32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .d1_in          (d1_in),
        .d2_in          (d2_in),
        .rs_in          (rs_in),
        .rt_in          (rt_in),
        .rd_in          (rd_in),
        .muxctrl_in     (muxctrl_in),
        .memctrl_in     (memctrl_in),
        .aluctrl_in     (aluctrl_in),
        .fwd_exmem_data (fwd_exmem_data),
        .fwd_exmem_dest (fwd_exmem_dest),
        .fwd_exmem_we   (fwd_exmem_we),
        .fwd_memwb_data (fwd_memwb_data),
        .fwd_memwb_dest (fwd_memwb_dest),
        .fwd_memwb_we   (fwd_memwb_we),
        .stall          (stall),
        .alu_result     (alu_result),
        .store_data     (store_data),
        .dest_out       (dest_out),
        .muxctrl_out    (muxctrl_out),
        .memctrl_out    (memctrl_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %08h, expected %08h", name, $time, act, exp);
        end
    endtask

    function automatic bit is_md(input logic [3:0] op);
        return (op >= 4'd9) && (op <= 4'd12);
    endfunction

    function automatic logic [31:0] fwd_val(input logic [4:0] r, input logic [31:0] d);
        if (fwd_exmem_we && fwd_exmem_dest == r && r != 5'd0) return fwd_exmem_data;
        if (fwd_memwb_we && fwd_memwb_dest == r && r != 5'd0) return fwd_memwb_data;
        return d;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLL:  return a << b[4:0];
            OP_SUB:  return a - b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_MFHI: return m_hi;
            OP_MFLO: return m_lo;
            OP_SRL:  return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic md_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == OP_MULT) begin
            p = sa * sb;
            {hi, lo} = p;
        end else if (op == OP_MULTU) begin
            p = {32'd0, a} * {32'd0, b};
            {hi, lo} = p;
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (op == OP_DIV) begin
            q = sa / sb;
            r = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    function automatic bit exp_stall();
        return !reset && ((m_left > 0) || (!m_done && is_md(aluctrl_in)));
    endfunction

    task automatic set_bubble();
        e_alu_v = 1'b1; e_full = 1'b0;
        e_alu = 0; e_mux = 0; e_mem = 0;
    endtask

    task automatic model_step();
        logic [31:0] a, rtv, b;
        if (reset) begin
            e_alu = 0; e_store = 0; e_dest = 0; e_mux = 0; e_mem = 0;
            e_alu_v = 1'b1; e_full = 1'b1;
            m_hi = 0; m_lo = 0; m_left = 0; m_done = 1'b0;
            return;
        end
        a   = fwd_val(rs_in, d1_in);
        rtv = fwd_val(rt_in, d2_in);
        b   = muxctrl_in[3] ? d2_in : rtv;
        if (m_left > 0) begin
            set_bubble();
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
            end
        end else if (m_done) begin
            e_alu_v = 1'b0; e_full = 1'b1;
            e_mux = {muxctrl_in[6:1], 1'b0};
            e_mem = memctrl_in; e_store = rtv;
            e_dest = muxctrl_in[2] ? rd_in : rt_in;
            m_done = 1'b0;
        end else if (is_md(aluctrl_in)) begin
            md_ref(aluctrl_in, a, b, p_hi, p_lo);
            m_left = MdStall - 1;
            set_bubble();
        end else begin
            e_alu_v = 1'b1; e_full = 1'b1;
            e_alu = alu_ref(aluctrl_in, a, b);
            e_mux = muxctrl_in; e_mem = memctrl_in; e_store = rtv;
            e_dest = muxctrl_in[2] ? rd_in : rt_in;
        end
    endtask

    initial forever begin
        @(posedge clock or posedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        if (m_ready) begin
            chk("stall", 32'(stall), 32'(exp_stall()));
            if (e_alu_v) chk("alu_result", alu_result, e_alu);
            chk("muxctrl_out", 32'(muxctrl_out), 32'(e_mux));
            chk("memctrl_out", 32'(memctrl_out), 32'(e_mem));
            if (e_full) begin
                chk("store_data", store_data, e_store);
                chk("dest_out", 32'(dest_out), 32'(e_dest));
            end
        end
    end

    task automatic set_fwd(input logic [31:0] exd, input logic [4:0] exdst, input logic exwe,
                           input logic [31:0] wbd, input logic [4:0] wbdst, input logic wbwe);
        fwd_exmem_data = exd; fwd_exmem_dest = exdst; fwd_exmem_we = exwe;
        fwd_memwb_data = wbd; fwd_memwb_dest = wbdst; fwd_memwb_we = wbwe;
    endtask

    task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [6:0] mux, input logic [1:0] mem);
        aluctrl_in = op; d1_in = a; d2_in = b; rs_in = rs; rt_in = rt; rd_in = rd;
        muxctrl_in = mux; memctrl_in = mem;
    endtask

    // Present one instruction and hold it while the stage stalls; returns stall cycles.
    task automatic instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [6:0] mux, input logic [1:0] mem, output int n);
        logic st;
        set_in(op, a, b, rs, rt, rd, mux, mem);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            st = stall;
            @(posedge clock);
            #1;
            if (!st) break;
            n++;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        set_fwd(32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0);
        set_in(OP_OR, 32'h1234, 32'h5, 5'd1, 5'd2, 5'd3, 7'h7F, 2'b11);
        repeat (2) @(posedge clock);
        #1;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_alu", alu_result, 32'd0);
        chk("reset_store", store_data, 32'd0);
        chk("reset_dest", 32'(dest_out), 32'd0);
        chk("reset_mux", 32'(muxctrl_out), 32'd0);
        chk("reset_mem", 32'(memctrl_out), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        m_ready = 1'b1;

        set_fwd(32'h11, 5'd5, 1'b1, 32'h22, 5'd5, 1'b1);
        instr(OP_ADD, 32'h99, 32'h1, 5'd5, 5'd6, 5'd10, 7'h05, 2'b00, n);
        chk("fwd_priority", alu_result, 32'h12);
        chk("dest_rd", 32'(dest_out), 32'd10);
        set_fwd(32'h11, 5'd5, 1'b0, 32'h22, 5'd5, 1'b1);
        instr(OP_ADD, 32'h99, 32'h1, 5'd5, 5'd6, 5'd10, 7'h01, 2'b00, n);
        chk("fwd_memwb", alu_result, 32'h23);
        chk("dest_rt", 32'(dest_out), 32'd6);
        set_fwd(32'hFF, 5'd0, 1'b1, 32'h0, 5'd0, 1'b0);
        instr(OP_OR, 32'h7, 32'h0, 5'd0, 5'd0, 5'd3, 7'h05, 2'b00, n);
        chk("reg0_no_fwd", alu_result, 32'h7);

        set_fwd(32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0);
        instr(OP_SLT, 32'hFFFF_FFFF, 32'h1, 5'd1, 5'd2, 5'd3, 7'h05, 2'b00, n);
        chk("slt", alu_result, 32'h1);
        instr(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd1, 5'd2, 5'd3, 7'h05, 2'b00, n);
        chk("sltu", alu_result, 32'h0);
        instr(OP_SUB, 32'h5, 32'h7, 5'd1, 5'd2, 5'd3, 7'h05, 2'b00, n);
        chk("sub", alu_result, 32'hFFFF_FFFE);
        instr(OP_SLL, 32'h1, 32'h24, 5'd1, 5'd2, 5'd3, 7'h05, 2'b00, n);
        chk("sll", alu_result, 32'h10);
        instr(OP_SRL, 32'h8000_0000, 32'd31, 5'd1, 5'd2, 5'd3, 7'h05, 2'b00, n);
        chk("srl", alu_result, 32'h1);
        instr(OP_NOR, 32'hF0F0_F0F0, 32'h0F0F_0F00, 5'd1, 5'd2, 5'd3, 7'h05, 2'b00, n);
        chk("nor", alu_result, 32'h0000_000F);
        instr(OP_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd1, 5'd2, 5'd3, 7'h05, 2'b00, n);
        chk("xor", alu_result, 32'hF0F0_F0F0);
        instr(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd1, 5'd2, 5'd3, 7'h05, 2'b00, n);
        chk("and", alu_result, 32'h0F00_0F00);

        set_fwd(32'hDEAD, 5'd8, 1'b1, 32'hBEEF, 5'd8, 1'b1);
        instr(OP_ADD, 32'h100, 32'h10, 5'd9, 5'd8, 5'd0, 7'h58, 2'b10, n);
        chk("store_addr_imm", alu_result, 32'h110);
        chk("store_data_fwd", store_data, 32'hDEAD);
        chk("store_mux_pass", 32'(muxctrl_out), 32'h58);
        chk("store_mem_pass", 32'(memctrl_out), 32'h2);
        set_fwd(32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0);

        instr(OP_MULT, 32'hFFFF_FFFD, 32'd7, 5'd1, 5'd2, 5'd3, 7'h05, 2'b00, n);
        chk("mult_stall_cycles", 32'(n), 32'd33);
        chk("mult_retire_no_write", 32'(muxctrl_out), 32'h04);
        instr(OP_MFLO, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, 7'h05, 2'b00, n);
        chk("mult_lo", alu_result, 32'hFFFF_FFEB);
        instr(OP_MFHI, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, 7'h05, 2'b00, n);
        chk("mult_hi", alu_result, 32'hFFFF_FFFF);

        instr(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 5'd2, 5'd3, 7'h05, 2'b00, n);
        instr(OP_MFLO, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, 7'h05, 2'b00, n);
        chk("div_lo", alu_result, 32'hFFFF_FFFD);
        instr(OP_MFHI, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, 7'h05, 2'b00, n);
        chk("div_hi", alu_result, 32'hFFFF_FFFF);

        instr(OP_DIVU, 32'd9, 32'd0, 5'd1, 5'd2, 5'd3, 7'h05, 2'b00, n);
        chk("div0_stall_cycles", 32'(n), 32'd33);
        instr(OP_MFLO, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, 7'h05, 2'b00, n);
        chk("div0_lo", alu_result, 32'hFFFF_FFFF);
        instr(OP_MFHI, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, 7'h05, 2'b00, n);
        chk("div0_hi", alu_result, 32'd9);

        instr(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 5'd2, 5'd3, 7'h05, 2'b00, n);
        instr(OP_MFLO, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, 7'h05, 2'b00, n);
        chk("multu_lo", alu_result, 32'h1);
        instr(OP_MFHI, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, 7'h05, 2'b00, n);
        chk("multu_hi", alu_result, 32'hFFFF_FFFE);

        set_in(OP_DIV, 32'd100, 32'd7, 5'd1, 5'd2, 5'd3, 7'h05, 2'b00);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("midop_reset_stall", 32'(stall), 32'd0);
        chk("midop_reset_alu", alu_result, 32'd0);
        chk("midop_reset_mux", 32'(muxctrl_out), 32'd0);
        chk("midop_reset_dest", 32'(dest_out), 32'd0);
        set_in(OP_AND, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 7'h00, 2'b00);
        @(negedge clock);
        reset = 1'b0;
        instr(OP_MFHI, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, 7'h05, 2'b00, n);
        chk("after_reset_hi", alu_result, 32'd0);
        instr(OP_MFLO, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, 7'h05, 2'b00, n);
        chk("after_reset_lo", alu_result, 32'd0);

        repeat (2) @(posedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
